// File: rtl/hfg_control_param.sv
// Haar-feature-generator controller, parametrised.
// Walks the cascade stage by stage for one detection window: streams feature
// descriptors from the feature ROM, issues IIB corner reads, packs per-feature
// sign bits into groups for the evaluator and reports the window verdict.
module hfg_control_param #(
   parameter int IIB_AW  = 9,
   parameter int DW      = 9,
   parameter int FAW     = 12,
   parameter int NCORNER = 8,
   parameter int GROUP   = 8,
   parameter int NSTAGE  = 25,
   parameter int SAW     = 5,
   parameter int CW      = 7
) (
   input  logic                       iClk,
   input  logic                       iReset_n,
   input  logic                       iRun,
   input  logic                       iStart,
   input  logic [IIB_AW-1:0]          iBase,
   output logic [FAW-1:0]             oFaddr,
   input  logic [DW-1:0]              iFdata,
   output logic [SAW-1:0]             oStage_addr,
   input  logic [CW-1:0]              iStage_cnt,
   output logic [IIB_AW-1:0]          oAddr_IIB,
   output logic                       oRdreq_IIB,
   output logic [GROUP-1:0]           oSign,
   output logic [$clog2(GROUP+1)-1:0] oValid_cnt,
   output logic [FAW-1:0]             oFeat_base,
   output logic                       oFull,
   input  logic                       iReady,
   output logic                       oStage_end,
   output logic [SAW-1:0]             oStage_idx,
   input  logic                       iStage_pass,
   input  logic                       iStage_fail,
   output logic                       oDone,
   output logic                       oFace,
   output logic                       oBusy
);

   localparam int VW = $clog2(GROUP + 1);
   localparam int WW = $clog2(NCORNER + 1);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR   = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] FETCH    = 3'd3;
   localparam logic [2:0] DRAIN    = 3'd4;
   localparam logic [2:0] WAIT_RDY = 3'd5;
   localparam logic [2:0] VERDICT  = 3'd6;

   logic [2:0]        state_q,     state_d;
   logic [IIB_AW-1:0] base_q,      base_d;
   logic [SAW-1:0]    stage_idx_q, stage_idx_d;
   logic [FAW-1:0]    faddr_q,     faddr_d;
   logic [CW-1:0]     feat_left_q, feat_left_d;
   logic [VW-1:0]     grp_n_q,     grp_n_d;
   logic [WW-1:0]     wcnt_q,      wcnt_d;
   logic [VW-1:0]     fcnt_q,      fcnt_d;
   logic [VW-1:0]     slot_q,      slot_d;
   logic              dvalid_q,    dvalid_d;
   logic              dhdr_q,      dhdr_d;
   logic [GROUP-1:0]  sign_q,      sign_d;
   logic [VW-1:0]     valid_cnt_q, valid_cnt_d;
   logic [FAW-1:0]    feat_base_q, feat_base_d;
   logic              full_q,      full_d;
   logic [IIB_AW-1:0] addr_iib_q,  addr_iib_d;
   logic              rdreq_q,     rdreq_d;
   logic              stage_end_q, stage_end_d;
   logic              done_q,      done_d;
   logic              face_q,      face_d;
   logic [CW-1:0]     remain;

   // Header bits above the sign and corner bits above the offset carry no meaning here.
   logic fdata_unused;
   assign fdata_unused = ^iFdata;

   function automatic logic [VW-1:0] grp_of(input logic [CW-1:0] left);
      if (int'(left) >= GROUP) return VW'(GROUP);
      return VW'(left);
   endfunction

   // Next-state: window sequencing plus the ROM-return datapath (1-cycle tag pipe).
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      stage_idx_d = stage_idx_q;
      faddr_d     = faddr_q;
      feat_left_d = feat_left_q;
      grp_n_d     = grp_n_q;
      wcnt_d      = wcnt_q;
      fcnt_d      = fcnt_q;
      slot_d      = slot_q;
      sign_d      = sign_q;
      valid_cnt_d = valid_cnt_q;
      feat_base_d = feat_base_q;
      addr_iib_d  = addr_iib_q;
      face_d      = face_q;
      full_d      = 1'b0;
      rdreq_d     = 1'b0;
      stage_end_d = 1'b0;
      done_d      = 1'b0;
      remain      = feat_left_q - CW'(grp_n_q);
      dvalid_d    = (state_q == FETCH);
      dhdr_d      = (wcnt_q == '0);

      if (dvalid_q) begin
         if (dhdr_q) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
               if (i == int'(slot_q)) sign_d[i] = iFdata[0];
            end
            slot_d = slot_q + VW'(1);
         end else begin
            addr_iib_d = base_q + iFdata[IIB_AW-1:0];
            rdreq_d    = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (iStart) begin
               base_d      = iBase;
               stage_idx_d = '0;
               faddr_d     = '0;
               feat_base_d = '0;
               face_d      = 1'b0;
               state_d     = S_ADDR;
            end
         end
         S_ADDR: state_d = S_LOAD;
         S_LOAD: begin
            feat_left_d = iStage_cnt;
            wcnt_d      = '0;
            fcnt_d      = '0;
            slot_d      = '0;
            if (iStage_cnt == '0) begin
               if (stage_idx_q == SAW'(NSTAGE - 1)) begin
                  done_d  = 1'b1;
                  face_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stage_idx_d = stage_idx_q + SAW'(1);
                  state_d     = S_ADDR;
               end
            end else begin
               grp_n_d = grp_of(iStage_cnt);
               state_d = FETCH;
            end
         end
         FETCH: begin
            faddr_d = faddr_q + FAW'(1);
            if (wcnt_q == WW'(NCORNER)) begin
               wcnt_d = '0;
               fcnt_d = fcnt_q + VW'(1);
               if (fcnt_q + VW'(1) == grp_n_q) state_d = DRAIN;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         DRAIN: begin
            // The last word is always a corner, so an empty tag pipe means its strobe is out now.
            if (!dvalid_q) begin
               full_d      = 1'b1;
               valid_cnt_d = grp_n_q;
               state_d     = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (iReady) begin
               sign_d      = '0;
               slot_d      = '0;
               wcnt_d      = '0;
               fcnt_d      = '0;
               feat_base_d = feat_base_q + FAW'(grp_n_q);
               feat_left_d = remain;
               if (remain != '0) begin
                  grp_n_d = grp_of(remain);
                  state_d = FETCH;
               end else begin
                  stage_end_d = 1'b1;
                  state_d     = VERDICT;
               end
            end
         end
         VERDICT: begin
            if (iStage_fail) begin
               done_d  = 1'b1;
               face_d  = 1'b0;
               state_d = IDLE;
            end else if (iStage_pass) begin
               if (stage_idx_q == SAW'(NSTAGE - 1)) begin
                  done_d  = 1'b1;
                  face_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  stage_idx_d = stage_idx_q + SAW'(1);
                  state_d     = S_ADDR;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers: async reset, synchronous clear while iRun is low.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n || !iRun) begin
         state_q     <= IDLE;
         base_q      <= '0;
         stage_idx_q <= '0;
         faddr_q     <= '0;
         feat_left_q <= '0;
         grp_n_q     <= '0;
         wcnt_q      <= '0;
         fcnt_q      <= '0;
         slot_q      <= '0;
         dvalid_q    <= 1'b0;
         dhdr_q      <= 1'b0;
         sign_q      <= '0;
         valid_cnt_q <= '0;
         feat_base_q <= '0;
         full_q      <= 1'b0;
         addr_iib_q  <= '0;
         rdreq_q     <= 1'b0;
         stage_end_q <= 1'b0;
         done_q      <= 1'b0;
         face_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         stage_idx_q <= stage_idx_d;
         faddr_q     <= faddr_d;
         feat_left_q <= feat_left_d;
         grp_n_q     <= grp_n_d;
         wcnt_q      <= wcnt_d;
         fcnt_q      <= fcnt_d;
         slot_q      <= slot_d;
         dvalid_q    <= dvalid_d;
         dhdr_q      <= dhdr_d;
         sign_q      <= sign_d;
         valid_cnt_q <= valid_cnt_d;
         feat_base_q <= feat_base_d;
         full_q      <= full_d;
         addr_iib_q  <= addr_iib_d;
         rdreq_q     <= rdreq_d;
         stage_end_q <= stage_end_d;
         done_q      <= done_d;
         face_q      <= face_d;
      end
   end

   assign oFaddr      = faddr_q;
   assign oStage_addr = stage_idx_q;
   assign oStage_idx  = stage_idx_q;
   assign oAddr_IIB   = addr_iib_q;
   assign oRdreq_IIB  = rdreq_q;
   assign oSign       = sign_q;
   assign oValid_cnt  = valid_cnt_q;
   assign oFeat_base  = feat_base_q;
   assign oFull       = full_q;
   assign oStage_end  = stage_end_q;
   assign oDone       = done_q;
   assign oFace       = face_q;
   assign oBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_hfg_control_param.sv
// Bench for hfg_control_param: ROM models, a transaction-level reference of
// one window (expected IIB reads, groups, verdict) and randomized windows.
module tb_hfg_control_param;

   localparam int IIB_AW = 9;
   localparam int DW     = 9;
   localparam int FAW    = 12;
   localparam int NC     = 2;
   localparam int GRP    = 2;
   localparam int NST    = 3;
   localparam int SAW    = 5;
   localparam int CW     = 7;
   localparam int VW     = $clog2(GRP + 1);
   localparam int LIMIT  = 3000;

   logic              iClk = 1'b0;
   logic              iReset_n, iRun, iStart, iReady, iStage_pass, iStage_fail;
   logic [IIB_AW-1:0] iBase;
   logic [DW-1:0]     iFdata;
   logic [CW-1:0]     iStage_cnt;
   logic [FAW-1:0]    oFaddr, oFeat_base;
   logic [SAW-1:0]    oStage_addr, oStage_idx;
   logic [IIB_AW-1:0] oAddr_IIB;
   logic              oRdreq_IIB, oFull, oStage_end, oDone, oFace, oBusy;
   logic [GRP-1:0]    oSign;
   logic [VW-1:0]     oValid_cnt;

   hfg_control_param #(
      .IIB_AW(IIB_AW), .DW(DW), .FAW(FAW), .NCORNER(NC), .GROUP(GRP),
      .NSTAGE(NST), .SAW(SAW), .CW(CW)
   ) dut (
      .iClk(iClk), .iReset_n(iReset_n), .iRun(iRun), .iStart(iStart), .iBase(iBase),
      .oFaddr(oFaddr), .iFdata(iFdata), .oStage_addr(oStage_addr), .iStage_cnt(iStage_cnt),
      .oAddr_IIB(oAddr_IIB), .oRdreq_IIB(oRdreq_IIB), .oSign(oSign), .oValid_cnt(oValid_cnt),
      .oFeat_base(oFeat_base), .oFull(oFull), .iReady(iReady), .oStage_end(oStage_end),
      .oStage_idx(oStage_idx), .iStage_pass(iStage_pass), .iStage_fail(iStage_fail),
      .oDone(oDone), .oFace(oFace), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;

   // Latency-1 ROM models.
   logic [DW-1:0] fmem [0:(1<<FAW)-1];
   logic [CW-1:0] smem [0:(1<<SAW)-1];
   always @(posedge iClk) begin
      iFdata     <= fmem[oFaddr];
      iStage_cnt <= smem[oStage_addr];
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({oFaddr, oStage_addr, oAddr_IIB, oRdreq_IIB, oSign, oValid_cnt, oFeat_base,
                  oFull, oStage_end, oStage_idx, oDone, oFace, oBusy});
   endfunction

   typedef struct {
      logic [GRP-1:0] sign;
      int             vcnt;
      int             fbase;
   } grp_t;

   // Window configuration: verdict code 0 = pass, 1 = fail, 2 = pass and fail together.
   int cnt  [NST];
   int verd [NST];
   int base;

   int   exp_rd   [$];
   grp_t exp_grp  [$];
   int   exp_verd [$];
   int   exp_send, exp_face, exp_sidx;

   // Reference: features laid out as header + NC corners, consumed in GRP-sized chunks.
   task automatic model_window();
      int fidx, fbase, left, g, w;
      logic [DW-1:0] hdr;
      grp_t gr;
      bit fin;
      exp_rd.delete(); exp_grp.delete(); exp_verd.delete();
      exp_send = 0; exp_face = 0; exp_sidx = 0;
      fidx = 0; fbase = 0; fin = 0;
      for (int s = 0; s < NST; s++) begin
         if (fin) break;
         exp_sidx = s;
         if (cnt[s] == 0) begin
            if (s == NST - 1) exp_face = 1;
            continue;
         end
         left = cnt[s];
         while (left > 0) begin
            g = (left < GRP) ? left : GRP;
            gr.sign = '0;
            for (int j = 0; j < g; j++) begin
               w = fidx * (1 + NC);
               hdr = fmem[w % (1 << FAW)];
               gr.sign[j] = hdr[0];
               for (int c = 1; c <= NC; c++)
                  exp_rd.push_back((base + int'(fmem[(w + c) % (1 << FAW)]) % (1 << IIB_AW)) % (1 << IIB_AW));
               fidx++;
            end
            gr.vcnt  = g;
            gr.fbase = fbase % (1 << FAW);
            exp_grp.push_back(gr);
            fbase += g;
            left  -= g;
         end
         exp_send++;
         exp_verd.push_back(verd[s]);
         if (verd[s] != 0) begin
            exp_face = 0;
            fin = 1;
         end else if (s == NST - 1) begin
            exp_face = 1;
         end
      end
   endtask

   task automatic rand_rom();
      for (int i = 0; i < 64; i++) fmem[i] = DW'($urandom);
   endtask

   // One window. stall: withhold iReady 20 cycles per group; noise: spurious iStart/iBase
   // while busy; drop_at>0: disturb at that cycle (async=1: iReset_n, else iRun); timing: exact cycles.
   task automatic run_window(input int stall, input int noise, input int drop_at,
                             input int async_rst, input int timing);
      int cyc, rdy_wait, ver_wait, v, sends;
      bit pend_full, pend_ver, finished;
      logic [GRP-1:0] h_sign;
      logic [VW-1:0]  h_vcnt;
      logic [FAW-1:0] h_fbase, h_faddr;
      int rd_cyc [$];
      int exp_cyc [4];
      grp_t gr;
      exp_cyc = '{6, 7, 9, 10};
      for (int s = 0; s < NST; s++) smem[s] = CW'(cnt[s]);
      model_window();
      pend_full = 0; pend_ver = 0; sends = 0; rdy_wait = 0; ver_wait = 0; finished = 0;
      h_sign = '0; h_vcnt = '0; h_fbase = '0; h_faddr = '0;
      @(negedge iClk);
      iBase = IIB_AW'(base);
      iStart = 1'b1;
      cyc = 0;
      while (1) begin
         @(negedge iClk);
         cyc++;
         iStart = 1'b0; iReady = 1'b0; iStage_pass = 1'b0; iStage_fail = 1'b0;
         if (drop_at > 0 && !async_rst && cyc == drop_at + 1) begin
            chk("run_low_clear", outs_vec(), 64'd0);
            iRun = 1'b1;
            return;
         end
         if (cyc == 3) chk("faddr_first", 64'(oFaddr), 64'd0);
         if (oRdreq_IIB) begin
            if (timing) rd_cyc.push_back(cyc);
            chk("rd_expected", 64'(exp_rd.size() > 0), 64'd1);
            if (exp_rd.size() > 0) chk("iib_addr", 64'(oAddr_IIB), 64'(exp_rd.pop_front()));
         end
         if (oFull) begin
            chk("grp_expected", 64'(exp_grp.size() > 0), 64'd1);
            if (exp_grp.size() > 0) begin
               gr = exp_grp.pop_front();
               chk("grp_sign", 64'(oSign), 64'(gr.sign));
               chk("grp_valid", 64'(oValid_cnt), 64'(gr.vcnt));
               chk("grp_fbase", 64'(oFeat_base), 64'(gr.fbase));
            end
            if (timing) chk("full_cycle", 64'(cyc), 64'd11);
            h_sign = oSign; h_vcnt = oValid_cnt; h_fbase = oFeat_base; h_faddr = oFaddr;
            pend_full = 1;
            rdy_wait = stall ? 20 : $urandom_range(0, 3);
         end else if (pend_full) begin
            chk("hold_sign", 64'(oSign), 64'(h_sign));
            chk("hold_valid", 64'(oValid_cnt), 64'(h_vcnt));
            chk("hold_fbase", 64'(oFeat_base), 64'(h_fbase));
            chk("hold_faddr", 64'(oFaddr), 64'(h_faddr));
         end
         if (oStage_end) begin
            sends++;
            pend_ver = 1;
            ver_wait = $urandom_range(0, 3);
         end
         if (oDone) begin
            chk("face", 64'(oFace), 64'(exp_face));
            chk("stage_idx_end", 64'(oStage_idx), 64'(exp_sidx));
            chk("rd_left", 64'(exp_rd.size()), 64'd0);
            chk("grp_left", 64'(exp_grp.size()), 64'd0);
            chk("stage_end_n", 64'(sends), 64'(exp_send));
            finished = 1;
            break;
         end
         if (cyc > LIMIT) begin
            chk("done_in_budget", 64'(cyc), 64'(LIMIT));
            break;
         end
         if (pend_full) begin
            if (rdy_wait == 0) begin iReady = 1'b1; pend_full = 0; end
            else rdy_wait--;
         end
         if (pend_ver) begin
            if (ver_wait == 0) begin
               v = (exp_verd.size() > 0) ? exp_verd.pop_front() : 0;
               iStage_pass = (v != 1);
               iStage_fail = (v != 0);
               pend_ver = 0;
            end else ver_wait--;
         end
         if (noise && $urandom_range(0, 2) == 0) begin
            iStart = 1'b1;
            iBase  = IIB_AW'($urandom);
         end
         if (drop_at > 0 && cyc == drop_at) begin
            if (async_rst) begin
               #2 iReset_n = 1'b0;
               #1 chk("async_reset_clear", outs_vec(), 64'd0);
               @(negedge iClk);
               iReset_n = 1'b1;
               iStart = 1'b0;
               return;
            end
            iRun = 1'b0;
         end
      end
      iStart = 1'b0; iReady = 1'b0; iStage_pass = 1'b0; iStage_fail = 1'b0;
      if (timing) begin
         chk("rd_count", 64'(rd_cyc.size()), 64'd4);
         for (int i = 0; i < rd_cyc.size() && i < 4; i++)
            chk("rd_cycle", 64'(rd_cyc[i]), 64'(exp_cyc[i]));
      end
      if (finished) begin
         @(negedge iClk);
         chk("face_hold", 64'(oFace), 64'(exp_face));
         chk("done_pulse", 64'(oDone), 64'd0);
         chk("idle_busy", 64'(oBusy), 64'd0);
      end
   endtask

   initial begin
      iReset_n = 1'b0; iRun = 1'b1; iStart = 1'b0; iReady = 1'b0;
      iStage_pass = 1'b0; iStage_fail = 1'b0; iBase = '0;
      for (int i = 0; i < (1 << FAW); i++) fmem[i] = '0;
      for (int i = 0; i < (1 << SAW); i++) smem[i] = '0;
      repeat (3) @(negedge iClk);
      chk("reset_state", outs_vec(), 64'd0);
      iReset_n = 1'b1;
      @(negedge iClk);

      // Directed: two features, signs 1/0, offsets 3,5,7,9 on base 4.
      rand_rom();
      fmem[0] = 9'd1; fmem[1] = 9'd3; fmem[2] = 9'd5;
      fmem[3] = 9'd0; fmem[4] = 9'd7; fmem[5] = 9'd9;
      cnt = '{2, 0, 0}; verd = '{0, 0, 0}; base = 4;
      run_window(0, 0, 0, 0, 1);

      // Three features in one stage: groups of 2 then 1.
      rand_rom(); cnt = '{3, 0, 0}; verd = '{0, 0, 0}; base = 17;
      run_window(0, 0, 0, 0, 0);

      // Empty middle stage skipped, fail on the last stage.
      rand_rom(); cnt = '{1, 0, 1}; verd = '{0, 0, 1}; base = 100;
      run_window(0, 0, 0, 0, 0);

      // Address wrap with iStart/iBase noise while busy.
      rand_rom(); fmem[1] = 9'd5; fmem[2] = 9'd4;
      cnt = '{1, 0, 0}; verd = '{0, 0, 0}; base = 510;
      run_window(0, 1, 0, 0, 0);

      // Long iReady stall, then pass and fail together.
      rand_rom(); cnt = '{3, 2, 0}; verd = '{0, 2, 0}; base = 300;
      run_window(1, 0, 0, 0, 0);

      // iRun dropped mid-FETCH, then a clean window.
      rand_rom(); cnt = '{4, 1, 1}; verd = '{0, 0, 0}; base = 55;
      run_window(0, 0, 5, 0, 0);
      run_window(0, 0, 0, 0, 0);

      // Async reset mid-FETCH, then a clean window.
      run_window(0, 0, 6, 1, 0);
      run_window(0, 0, 0, 0, 0);

      // Randomized windows.
      for (int n = 0; n < 30; n++) begin
         rand_rom();
         for (int s = 0; s < NST; s++) begin
            cnt[s]  = $urandom_range(0, 5);
            verd[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         end
         base = $urandom_range(0, (1 << IIB_AW) - 1);
         run_window(0, int'($urandom_range(0, 1)), 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
